// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the PC / inst_mem / ID / Registers / BranchComp datapath.
// Drives fetch/data handshakes, datapath write strobes, run/halt/step control and a timeout trap.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_sys,
  input  logic             reg_we_dec,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             running,
  output logic             retired,
  output logic [CNT_W-1:0] instret,
  output logic             err,
  output logic [2:0]       state
);

  localparam logic [2:0] S_HALT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam int unsigned TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [TW-1:0]    r_tcnt;
  logic             r_halt;
  logic             r_step;
  logic [CNT_W-1:0] r_instret;

  logic [2:0] w_next;
  logic       w_timeout;
  logic       w_stop;
  logic       w_running;
  logic       w_enter_wait;

  assign w_timeout = (r_tcnt == TLAST);
  // halt_req in the WB cycle itself must still stop the machine, so it bypasses the latch here
  assign w_stop    = r_halt | halt_req | r_step | is_sys;
  assign w_running = (r_state != S_HALT) && (r_state != S_ERROR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT:   if (start || step) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack)       w_next = S_WB;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_WB:     w_next = w_stop ? S_HALT : S_FETCH;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_HALT;
    endcase
  end

  assign w_enter_wait = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_tcnt    <= '0;
      r_halt    <= 1'b0;
      r_step    <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;

      if (w_enter_wait)
        r_tcnt <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_tcnt <= r_tcnt + TW'(1);

      if (r_state == S_HALT)
        r_step <= step & ~start;
      else if (w_next == S_HALT)
        r_step <= 1'b0;

      if (w_next == S_HALT)
        r_halt <= 1'b0;
      else if (w_running)
        r_halt <= r_halt | halt_req;

      if (r_state == S_WB)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign imem_req = (r_state == S_FETCH);
  assign ir_we    = (r_state == S_FETCH) & imem_ack;
  assign dmem_req = (r_state == S_MEM);
  assign dmem_we  = (r_state == S_MEM) & is_store;
  assign reg_we   = (r_state == S_WB) & reg_we_dec & ~is_store;
  assign pc_we    = (r_state == S_WB);
  assign retired  = (r_state == S_WB);
  assign running  = w_running;
  assign err      = (r_state == S_ERROR);
  assign instret  = r_instret;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic compared cycle by cycle against a behavioural model of the sequencer.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, step, halt_req, is_load, is_store, is_sys, reg_we_dec;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        ir_we, pc_we, reg_we, running, retired, err;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
    .is_load(is_load), .is_store(is_store), .is_sys(is_sys), .reg_we_dec(reg_we_dec),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .running(running),
    .retired(retired), .instret(instret), .err(err), .state(state)
  );

  int checks = 0;
  int errors = 0;
  int ret_seen = 0;

  // Reference model: phase number, cycle index inside a memory wait (1 = entry cycle),
  // pending stop requests and the retirement count.
  int          m_st = 0;
  int          m_wait = 0;
  bit          m_halt = 0;
  bit          m_step = 0;
  logic [31:0] m_cnt = '0;

  typedef struct {
    logic [8:0]  in;    // {start,step,halt_req,is_load,is_store,is_sys,reg_we_dec,imem_ack,dmem_ack}
    logic [2:0]  est;
    logic [8:0]  eo;    // {imem_req,ir_we,dmem_req,dmem_we,reg_we,pc_we,retired,running,err}
    int          ecnt;
  } row_t;

  row_t tbl[31];

  function automatic row_t R(input logic [8:0] in, input logic [2:0] s, input logic [8:0] o, input int n);
    row_t r;
    r.in = in; r.est = s; r.eo = o; r.ecnt = n;
    return r;
  endfunction

  function automatic logic [8:0] dut_o();
    return {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retired, running, err};
  endfunction

  function automatic logic [8:0] model_o();
    logic [8:0] o;
    o    = '0;
    o[8] = (m_st == 1);
    o[7] = (m_st == 1) && imem_ack;
    o[6] = (m_st == 4);
    o[5] = (m_st == 4) && is_store;
    o[4] = (m_st == 5) && reg_we_dec && !is_store;
    o[3] = (m_st == 5);
    o[2] = (m_st == 5);
    o[1] = (m_st >= 1) && (m_st <= 5);
    o[0] = (m_st == 6);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_wait = 0; m_halt = 0; m_step = 0; m_cnt = '0;
    end else begin
      if (m_st >= 1 && m_st <= 4 && halt_req) m_halt = 1;
      case (m_st)
        0: if (start) begin m_st = 1; m_step = 0; m_wait = 1; end
           else if (step) begin m_st = 1; m_step = 1; m_wait = 1; end
        1: if (imem_ack) m_st = 2; else if (m_wait == TO) m_st = 6; else m_wait++;
        2: m_st = 3;
        3: if (is_load || is_store) begin m_st = 4; m_wait = 1; end else m_st = 5;
        4: if (dmem_ack) m_st = 5; else if (m_wait == TO) m_st = 6; else m_wait++;
        5: begin
          m_cnt = m_cnt + 32'd1;
          if (m_halt || halt_req || m_step || is_sys) begin
            m_st = 0; m_halt = 0; m_step = 0;
          end else begin
            m_st = 1; m_wait = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    ret_seen += int'(retired);
    chk("state", state, m_st[2:0]);
    chk("strobes", dut_o(), model_o());
    chk("instret", instret, m_cnt);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [8:0] v);
    {start, step, halt_req, is_load, is_store, is_sys, reg_we_dec, imem_ack, dmem_ack} = v;
  endtask

  task automatic run(input int n, input logic [8:0] v);
    for (int i = 0; i < n; i++) begin
      set_in(v);
      tick();
    end
  endtask

  localparam logic [8:0] ALU  = 9'b000000110;
  localparam logic [8:0] LD   = 9'b000100110;
  localparam logic [8:0] ST   = 9'b000010111;
  localparam logic [8:0] FETO = 9'b110000010;
  localparam logic [8:0] RUNO = 9'b000000010;
  localparam logic [8:0] WBO  = 9'b000011110;

  logic [31:0] base;
  int          pct;

  initial begin
    rst = 1'b1;
    set_in('0);
    @(posedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", state, 3'd0);
    chk("reset_strobes", dut_o(), 9'b0);
    chk("reset_instret", instret, 32'd0);

    // Three ALU ops, a load with a 3-cycle ack delay, a store, then halt_req during a fetch.
    tbl[0] = R(9'b100000110, 3'd0, 9'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tbl[1 + 4*k] = R(ALU, 3'd1, FETO, k);
      tbl[2 + 4*k] = R(ALU, 3'd2, RUNO, k);
      tbl[3 + 4*k] = R(ALU, 3'd3, RUNO, k);
      tbl[4 + 4*k] = R(ALU, 3'd5, WBO,  k);
    end
    tbl[13] = R(LD, 3'd1, FETO, 3);
    tbl[14] = R(LD, 3'd2, RUNO, 3);
    tbl[15] = R(LD, 3'd3, RUNO, 3);
    tbl[16] = R(LD, 3'd4, 9'b001000010, 3);
    tbl[17] = R(LD, 3'd4, 9'b001000010, 3);
    tbl[18] = R(LD, 3'd4, 9'b001000010, 3);
    tbl[19] = R(9'b000100111, 3'd4, 9'b001000010, 3);
    tbl[20] = R(LD, 3'd5, WBO, 3);
    tbl[21] = R(ST, 3'd1, FETO, 4);
    tbl[22] = R(ST, 3'd2, RUNO, 4);
    tbl[23] = R(ST, 3'd3, RUNO, 4);
    tbl[24] = R(ST, 3'd4, 9'b001100010, 4);
    tbl[25] = R(9'b000010110, 3'd5, 9'b000001110, 4);
    tbl[26] = R(9'b001000110, 3'd1, FETO, 5);
    tbl[27] = R(ALU, 3'd2, RUNO, 5);
    tbl[28] = R(ALU, 3'd3, RUNO, 5);
    tbl[29] = R(ALU, 3'd5, WBO, 5);
    tbl[30] = R(ALU, 3'd0, 9'b0, 6);

    for (int i = 0; i < 31; i++) begin
      set_in(tbl[i].in);
      #1;
      chk($sformatf("tbl%0d_state", i), state, tbl[i].est);
      chk($sformatf("tbl%0d_strobes", i), dut_o(), tbl[i].eo);
      chk($sformatf("tbl%0d_instret", i), instret, 32'(tbl[i].ecnt));
      tick();
    end

    // Single step retires exactly one instruction.
    ret_seen = 0;
    run(1, 9'b010000010);
    run(7, ALU);
    #1;
    chk("step_retired", 32'(ret_seen), 32'd1);
    chk("step_state", state, 3'd0);
    chk("step_running", running, 1'b0);

    // start together with step free-runs.
    ret_seen = 0;
    run(1, 9'b110000110);
    run(8, ALU);
    #1;
    chk("startstep_retired", 32'(ret_seen), 32'd2);
    chk("startstep_running", running, 1'b1);
    chk("startstep_state", state, 3'd1);
    run(1, 9'b001000110);
    run(3, ALU);
    #1;
    chk("startstep_halted", state, 3'd0);

    // halt_req pulse during DECODE of the second instruction.
    base = m_cnt;
    run(1, 9'b100000110);
    run(5, ALU);
    run(1, 9'b001000110);
    run(2, ALU);
    run(1, ALU);
    #1;
    chk("haltreq_instret", instret, base + 32'd2);
    chk("haltreq_state", state, 3'd0);

    // ecall/ebreak halts after its own retirement.
    base = m_cnt;
    run(1, 9'b100000000);
    run(4, 9'b000001110);
    #1;
    chk("sys_instret", instret, base + 32'd1);
    chk("sys_state", state, 3'd0);

    // Acks arriving on the last allowed cycle of FETCH and MEM are accepted.
    run(1, 9'b100000000);
    run(TO - 1, 9'b000000000);
    run(1, 9'b000000010);
    #1;
    chk("fetch_last_ack", state, 3'd2);
    run(2, 9'b000100000);
    run(TO - 1, 9'b000100000);
    run(1, 9'b000100001);
    #1;
    chk("mem_last_ack", state, 3'd5);
    run(1, 9'b000001000);
    #1;
    chk("mem_last_halt", state, 3'd0);

    // Fetch timeout traps; start is ignored; reset recovers.
    run(1, 9'b100000000);
    run(TO, 9'b000000000);
    #1;
    chk("timeout_state", state, 3'd6);
    chk("timeout_err", err, 1'b1);
    run(3, 9'b100000010);
    #1;
    chk("error_sticky", state, 3'd6);
    rst = 1'b1;
    run(1, 9'b000000011);
    rst = 1'b0;
    #1;
    chk("recover_state", state, 3'd0);
    chk("recover_err", err, 1'b0);
    chk("recover_instret", instret, 32'd0);

    // Randomized traffic with segments of varying memory responsiveness.
    pct = 90;
    for (int c = 0; c < 6000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 95;
          1:       pct = 40;
          default: pct = 8;
        endcase
      end
      rst        = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 7) == 0);
      step       = ($urandom_range(0, 7) == 0);
      halt_req   = ($urandom_range(0, 15) == 0);
      is_load    = ($urandom_range(0, 3) == 0);
      is_store   = ($urandom_range(0, 3) == 0);
      is_sys     = ($urandom_range(0, 9) == 0);
      reg_we_dec = $urandom_range(0, 1) == 1;
      imem_ack   = ($urandom_range(0, 99) < pct);
      dmem_ack   = ($urandom_range(0, 99) < pct);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
